// File: rtl/aux_uart_boot_loader.sv
// rtl/aux_uart_boot_loader.sv - UART byte receiver that assembles little-endian words into boot writes
module aux_uart_boot_loader #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int TIMEOUT_BITS  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        boot_busy,
    output logic        boot_write,
    output logic [15:0] boot_addr,
    output logic [31:0] boot_wdata,
    output logic [3:0]  boot_ble,
    output logic        boot_done,
    output logic        frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int IDLE_W       = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] TO_M1   = IDLE_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic              rx_meta_q, rx_sync_q;
    logic [1:0]        state_q, state_d;
    logic              fe_wait_q, fe_wait_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [15:0]       addr_q, addr_d;
    logic              busy_q, busy_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              done_pend_q, done_pend_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       waddr_q, waddr_d;
    logic [3:0]        ble_q, ble_d;
    logic              ferr_q, ferr_d;
    logic              timeout_fire;

    // Two-flop synchronizer for the asynchronous rx line; idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign timeout_fire = busy_q && (state_q == IDLE) && (idle_cnt_q == TO_M1);

    // Receiver FSM, word assembly and session timeout; timeout overrides byte bookkeeping
    always_comb begin
        state_d     = state_q;
        fe_wait_d   = fe_wait_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        idle_cnt_d  = '0;
        done_pend_d = 1'b0;
        write_d     = 1'b0;
        done_d      = done_pend_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        ble_d       = ble_q;
        ferr_d      = ferr_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                if (fe_wait_q) begin
                    // Bad stop bit: hold off until the line returns high
                    if (rx_sync_q) begin
                        fe_wait_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d    = IDLE;
                        busy_d     = 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        case (byte_cnt_q)
                            2'd0: word_d[7:0]   = shift_q;
                            2'd1: word_d[15:8]  = shift_q;
                            2'd2: word_d[23:16] = shift_q;
                            default: begin
                                write_d = 1'b1;
                                wdata_d = {shift_q, word_q};
                                waddr_d = addr_q;
                                ble_d   = 4'b1111;
                                addr_d  = addr_q + 16'd4;
                                word_d  = '0;
                            end
                        endcase
                    end else begin
                        ferr_d    = 1'b1;
                        fe_wait_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
        endcase

        // Idle clocks count only inside a session with the receiver idle; a start bit clears them
        if (busy_q && (state_q == IDLE) && !timeout_fire && rx_sync_q) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        // End of session: flush any partial word, then done; a start bit on this cycle still loses
        if (timeout_fire) begin
            busy_d     = 1'b0;
            addr_d     = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            if (byte_cnt_q != 2'd0) begin
                write_d     = 1'b1;
                wdata_d     = {8'h00, word_q};
                waddr_d     = addr_q;
                done_pend_d = 1'b1;
                case (byte_cnt_q)
                    2'd1:    ble_d = 4'b0001;
                    2'd2:    ble_d = 4'b0011;
                    default: ble_d = 4'b0111;
                endcase
            end else begin
                done_d = 1'b1;
            end
        end
    end

    // State registers; reset abandons any byte or session in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fe_wait_q   <= 1'b0;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            idle_cnt_q  <= '0;
            done_pend_q <= 1'b0;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            ble_q       <= '0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fe_wait_q   <= fe_wait_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            idle_cnt_q  <= idle_cnt_d;
            done_pend_q <= done_pend_d;
            write_q     <= write_d;
            done_q      <= done_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            ble_q       <= ble_d;
            ferr_q      <= ferr_d;
        end
    end

    assign boot_busy   = busy_q;
    assign boot_write  = write_q;
    assign boot_addr   = waddr_q;
    assign boot_wdata  = wdata_q;
    assign boot_ble    = ble_q;
    assign boot_done   = done_q;
    assign frame_error = ferr_q;

endmodule

// File: doc/aux_uart_boot_loader.md
AUX_UART_BOOT_LOADER -- requirements
Module: aux_uart_boot_loader

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 50000000, meaning the clk rate in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 100, meaning the idle bit-times that end a boot session.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous UART receive line, idle high.
REQ-007 SHALL have port boot_busy, output, 1 bit: a boot session is in progress.
REQ-008 SHALL have port boot_write, output, 1 bit: one-cycle word write strobe.
REQ-009 SHALL have port boot_addr, output, 16 bits: byte address of the current write, word aligned.
REQ-010 SHALL have port boot_wdata, output, 32 bits: write data, little-endian.
REQ-011 SHALL have port boot_ble, output, 4 bits: byte lane enables for the write.
REQ-012 SHALL have port boot_done, output, 1 bit: one-cycle pulse at session end.
REQ-013 SHALL have port frame_error, output, 1 bit: sticky framing-error flag.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; input-to-decision latency 2 cycles.
REQ-015 SHALL set CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE (truncated) and HALF = CLKS_PER_BIT / 2.
REQ-016 SHALL use receiver states IDLE, START, DATA, STOP.
REQ-017 IDLE: on synchronized rx = 0, go to START and clear the bit counter.
REQ-018 START: after HALF cycles, sample rx. If 0, go to DATA; if 1, treat as a false start and return to IDLE.
REQ-019 DATA: sample rx every CLKS_PER_BIT cycles, 8 samples, LSB first; then go to STOP.
REQ-020 STOP: after CLKS_PER_BIT cycles, sample rx. If 1, accept the byte. If 0, set frame_error, discard the byte, and wait for rx = 1 before re-entering IDLE.
REQ-021 An accepted byte SHALL go into lane k of the word assembler, where k = byte count mod 4; the first byte of a session asserts boot_busy.
REQ-022 On the 4th byte, boot_write SHALL pulse the cycle after the stop-bit sample, with boot_ble = 4'b1111 and boot_addr = current address; the address then advances by 4.
REQ-023 boot_addr SHALL wrap from 16'hFFFC to 16'h0000 without an error indication.
REQ-024 boot_wdata/boot_addr/boot_ble SHALL be valid only while boot_write = 1; otherwise they hold their last values.
REQ-025 SHALL count idle clocks while boot_busy = 1 and the receiver is in IDLE, and clear the count on any start-bit detection.
REQ-026 At TIMEOUT_BITS * CLKS_PER_BIT idle clocks, a partial word SHALL be flushed with one boot_write: unreceived lanes zero, boot_ble = received lanes only (e.g. 2 bytes -> 4'b0011).
REQ-027 boot_done SHALL pulse one cycle after that flush, or on the timeout cycle if no partial word exists. boot_busy then drops, and the address and byte count return to 0.
REQ-028 boot_write and boot_done SHALL never be asserted in the same cycle.
REQ-029 A start bit arriving on the timeout cycle itself SHALL lose: the session ends and the new byte opens a new session at address 0.
REQ-030 frame_error SHALL clear only on reset; it SHALL not end a session.
REQ-031 The timeout SHALL never fire while boot_busy = 0.

Reset
REQ-032 reset = 1 SHALL asynchronously force IDLE, synchronizer flops = 1, all counters = 0, and boot_busy/boot_write/boot_done/frame_error = 0, boot_addr = 0, boot_wdata = 0, boot_ble = 0.
REQ-033 Reset asserted mid-byte or mid-session SHALL abandon that data entirely with no write or done pulse; after release, reception restarts at the next falling edge of rx.

Verification (CLK_FREQUENCY=800, BAUD_RATE=100 -> 8 clocks/bit, TIMEOUT_BITS=4)
REQ-034 Send bytes 0x78,0x56,0x34,0x12 -> one boot_write with addr 0x0000, wdata 0x12345678, ble 4'b1111.
REQ-035 Send 6 bytes 0x01..0x06, then idle -> writes 0x04030201 @0x0000 (ble 1111) and 0x00000605 @0x0004 (ble 0011), then boot_done 1 cycle later, boot_busy = 0.
REQ-036 Send byte 0xA5 with stop bit = 0 -> frame_error = 1, no byte counted; the next valid 4 bytes still write at addr 0x0000.
REQ-037 Pulse rx low for 3 clocks only -> false start; no byte, no error, boot_busy stays 0.
REQ-038 Preload the address to 0xFFFC via 16383 words, send 8 bytes -> writes at 0xFFFC then 0x0000.
REQ-039 Assert reset after the 2nd byte of a word -> no write, no done; all outputs at reset values; the next 4 bytes write at 0x0000.
